// File: rtl/sqd_evt_pkg.sv
// Shared types and helpers for the detection event logger.
// Optional drop counter is enabled with SQD_EVT_DROP_CNT_EN (see sqd_event_logger).
package sqd_evt_pkg;

  localparam int DEF_GAP_W = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TOT_W = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } evt_state_t;

  typedef struct packed {
    logic                 first;
    logic [DEF_GAP_W-1:0] gap;
  } evt_rec_t;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/sqd_evt_fifo.sv
// Show-ahead FIFO of gap records; a push into a full FIFO is accepted only when
// a pop happens on the same edge.
module sqd_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic         push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sqd_event_logger.sv
// Logs the gap between successive detections into a FIFO, plus total/overflow status.
// Define SQD_EVT_DROP_CNT_EN to add the DROP_CNT saturating drop counter.
//   state  | meaning
//   S_IDLE | no detection since reset; next record is marked FIRST
//   S_RUN  | at least one detection seen
module sqd_event_logger
  import sqd_evt_pkg::*;
#(
  parameter int GAP_W = DEF_GAP_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int TOT_W = DEF_TOT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Z_IN,
  input  logic             CLR,
  input  logic             EVT_READY,
  output logic             EVT_VALID,
  output logic [GAP_W-1:0] EVT_GAP,
  output logic             EVT_FIRST,
  output logic [TOT_W-1:0] EVT_TOTAL,
  output logic             FIFO_FULL,
`ifdef SQD_EVT_DROP_CNT_EN
  output logic [7:0]       DROP_CNT,
`endif
  output logic             OVERFLOW
);

  localparam logic [31:0] GAP_MAX = (32'd1 << GAP_W) - 32'd1;
  localparam logic [31:0] TOT_MAX = (32'd1 << TOT_W) - 32'd1;

  evt_state_t       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             rec_first;
  logic             empty, push_ok, pop, drop;
  logic [GAP_W:0]   rd_data;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = GAP_W'(sat_inc(32'(gap_q), GAP_MAX));
    rec_first = 1'b0;
    case (state_q)
      S_IDLE: if (Z_IN) begin
        rec_first = 1'b1;
        gap_d     = '0;
        state_d   = S_RUN;
      end
      S_RUN: if (Z_IN) begin
        gap_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop  = EVT_VALID & EVT_READY;
  assign drop = Z_IN & ~push_ok;

  sqd_evt_fifo #(.DEPTH(DEPTH), .W(GAP_W + 1)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (Z_IN),
    .pop     (pop),
    .wr_data ({rec_first, gap_q}),
    .rd_data (rd_data),
    .full    (FIFO_FULL),
    .empty   (empty),
    .push_ok (push_ok)
  );

  assign EVT_VALID = ~empty;
  assign EVT_FIRST = rd_data[GAP_W];
  assign EVT_GAP   = rd_data[GAP_W-1:0];

  // CLR restarts the status from this cycle's activity rather than from zero.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      EVT_TOTAL <= '0;
      OVERFLOW  <= 1'b0;
    end else if (CLR) begin
      EVT_TOTAL <= TOT_W'(Z_IN);
      OVERFLOW  <= drop;
    end else begin
      if (Z_IN) EVT_TOTAL <= TOT_W'(sat_inc(32'(EVT_TOTAL), TOT_MAX));
      if (drop) OVERFLOW <= 1'b1;
    end
  end

`ifdef SQD_EVT_DROP_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RESET)     DROP_CNT <= '0;
    else if (CLR)   DROP_CNT <= {7'd0, drop};
    else if (drop)  DROP_CNT <= 8'(sat_inc(32'(DROP_CNT), 32'd255));
  end
`endif

endmodule

// File: tb/tb_sqd_event_logger.sv
// Randomised and directed bench for sqd_event_logger against a queue-based model.
// Honours SQD_EVT_DROP_CNT_EN to also check DROP_CNT.
module tb_sqd_event_logger;
  import sqd_evt_pkg::*;

  localparam int GAP_W   = 8;
  localparam int DEPTH   = 4;
  localparam int TOT_W   = 16;
  localparam int GAP_MAX = 255;
  localparam int TOT_MAX = 65535;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             Z_IN = 1'b0;
  logic             CLR = 1'b0;
  logic             EVT_READY = 1'b0;
  logic             EVT_VALID;
  logic [GAP_W-1:0] EVT_GAP;
  logic             EVT_FIRST;
  logic [TOT_W-1:0] EVT_TOTAL;
  logic             FIFO_FULL;
  logic             OVERFLOW;
`ifdef SQD_EVT_DROP_CNT_EN
  logic [7:0]       DROP_CNT;
`endif

  always #5 CLK = ~CLK;

  sqd_event_logger #(.GAP_W(GAP_W), .DEPTH(DEPTH), .TOT_W(TOT_W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Z_IN      (Z_IN),
    .CLR       (CLR),
    .EVT_READY (EVT_READY),
    .EVT_VALID (EVT_VALID),
    .EVT_GAP   (EVT_GAP),
    .EVT_FIRST (EVT_FIRST),
    .EVT_TOTAL (EVT_TOTAL),
    .FIFO_FULL (FIFO_FULL),
`ifdef SQD_EVT_DROP_CNT_EN
    .DROP_CNT  (DROP_CNT),
`endif
    .OVERFLOW  (OVERFLOW)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: records held in a queue, gaps from absolute edge numbers.
  evt_rec_t    m_q[$];
  int unsigned m_cyc  = 0;
  int unsigned m_last = 0;
  bit          m_seen = 0;
  int unsigned m_tot  = 0;
  int unsigned m_drops = 0;
  bit          m_ovf  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, m_cyc, got, exp);
    end
  endtask

  task automatic model_edge(input bit z, input bit rdy, input bit clr, input bit rst);
    bit          full_pre, pop, drop;
    int unsigned gap;
    evt_rec_t    rec;
    m_cyc++;
    if (!rst) begin
      m_q.delete();
      m_tot = 0; m_drops = 0; m_ovf = 0; m_seen = 0;
      m_last = m_cyc;
      return;
    end
    full_pre = (m_q.size() == DEPTH);
    pop      = (m_q.size() > 0) && rdy;
    drop     = 0;
    if (pop) void'(m_q.pop_front());
    if (z) begin
      gap = m_cyc - m_last - 1;
      if (gap > GAP_MAX) gap = GAP_MAX;
      rec.first = !m_seen;
      rec.gap   = gap[GAP_W-1:0];
      m_seen = 1;
      m_last = m_cyc;
      if (!full_pre || pop) m_q.push_back(rec);
      else drop = 1;
    end
    if (clr) begin
      m_tot   = z;
      m_ovf   = drop;
      m_drops = drop;
    end else begin
      if (z && m_tot < TOT_MAX) m_tot++;
      if (drop) m_ovf = 1;
      if (drop && m_drops < 255) m_drops++;
    end
  endtask

  task automatic step(input bit z, input bit rdy, input bit clr, input bit rst);
    bit v;
    Z_IN = z; EVT_READY = rdy; CLR = clr; RESET = rst;
    @(posedge CLK);
    model_edge(z, rdy, clr, rst);
    #1;
    v = (m_q.size() > 0);
    chk("valid", 32'(EVT_VALID), 32'(v));
    chk("gap",   32'(EVT_GAP),   v ? 32'(m_q[0].gap) : 32'd0);
    chk("first", 32'(EVT_FIRST), v ? 32'(m_q[0].first) : 32'd0);
    chk("total", 32'(EVT_TOTAL), 32'(m_tot));
    chk("full",  32'(FIFO_FULL), 32'(m_q.size() == DEPTH));
    chk("ovf",   32'(OVERFLOW),  32'(m_ovf));
`ifdef SQD_EVT_DROP_CNT_EN
    chk("drops", 32'(DROP_CNT),  32'(m_drops));
`endif
  endtask

  initial begin
    // reset, first detection on the 5th cycle after release
    repeat (3) step(0, 1, 0, 0);
    repeat (4) step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("first_rec_gap", 32'(EVT_GAP), 32'd4);
    chk("first_rec_flag", 32'(EVT_FIRST), 32'd1);
    // back-to-back detections
    repeat (3) step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    chk("tot_after_b2b", 32'(EVT_TOTAL), 32'd4);
    // overfill with READY low, then full detect with simultaneous pop
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 1);
      step(0, 0, 0, 1);
    end
    chk("ovf_after_fill", 32'(OVERFLOW), 32'd1);
    step(1, 1, 0, 1);
    chk("full_kept", 32'(FIFO_FULL), 32'd1);
    repeat (6) step(0, 1, 0, 1);
    // gap saturation, then CLR with a detection
    repeat (300) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("sat_gap", 32'(EVT_GAP), 32'd255);
    step(1, 0, 1, 1);
    chk("clr_total", 32'(EVT_TOTAL), 32'd1);
    repeat (3) step(0, 1, 0, 1);
    // reset with records queued
    repeat (3) step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("rst_valid", 32'(EVT_VALID), 32'd0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("post_rst_first", 32'(EVT_FIRST), 32'd1);
    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      bit z, rdy, clr, rst;
      int unsigned mode;
      mode = (i / 500) % 4;
      case (mode)
        0: z = ($urandom_range(0, 1) == 0);
        1: z = ($urandom_range(0, 3) != 0);
        2: z = ($urandom_range(0, 15) == 0);
        default: z = ($urandom_range(0, 299) == 0);
      endcase
      rdy = (mode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 399) != 0);
      step(z, rdy, clr, rst);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
